// File: rtl/reg_file_cc_if.sv
// Bundle between the LC-3 datapath control and the register file / condition-code block.
// The master side drives indices, loads and the bus; the slave returns operands and flags.
interface reg_file_cc_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] bus;
    logic             ld_reg;
    logic [2:0]       dr;
    logic [2:0]       sr1;
    logic [2:0]       sr2;
    logic             ld_cc;
    logic             ld_ben;
    logic [2:0]       ir_cond;
    logic [WIDTH-1:0] sr1_out;
    logic [WIDTH-1:0] sr2_out;
    logic             n;
    logic             z;
    logic             p;
    logic             ben;

    modport master (
        output bus, ld_reg, dr, sr1, sr2, ld_cc, ld_ben, ir_cond,
        input  sr1_out, sr2_out, n, z, p, ben
    );

    modport slave (
        input  bus, ld_reg, dr, sr1, sr2, ld_cc, ld_ben, ir_cond,
        output sr1_out, sr2_out, n, z, p, ben
    );
endinterface

// File: rtl/reg_file_cc.sv
// LC-3 general-purpose register file R0-R7 with two combinational read ports,
// one synchronous write port, NZP condition codes and the branch-enable flag.
module reg_file_cc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8
) (
    input logic         clk,
    input logic         rst,
    reg_file_cc_if.slave rf
);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [2:0]       nzp_q;
    logic [2:0]       nzp_d;
    logic             ben_q;
    logic             ben_d;

    // Reads come straight from the flops: a write lands only after the edge.
    assign rf.sr1_out = regs_q[rf.sr1];
    assign rf.sr2_out = regs_q[rf.sr2];

    assign rf.n   = nzp_q[2];
    assign rf.z   = nzp_q[1];
    assign rf.p   = nzp_q[0];
    assign rf.ben = ben_q;

    always_comb begin
        regs_d = regs_q;
        if (rf.ld_reg) begin
            regs_d[rf.dr] = rf.bus;
        end
    end

    always_comb begin
        nzp_d = nzp_q;
        if (rf.ld_cc) begin
            if (rf.bus[WIDTH-1]) begin
                nzp_d = 3'b100;
            end else if (rf.bus == '0) begin
                nzp_d = 3'b010;
            end else begin
                nzp_d = 3'b001;
            end
        end
    end

    // BEN samples the flags held before this edge, even when ld_cc updates them alongside.
    always_comb begin
        ben_d = ben_q;
        if (rf.ld_ben) begin
            ben_d = |(rf.ir_cond & nzp_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            nzp_q <= 3'b010;
            ben_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            nzp_q  <= nzp_d;
            ben_q  <= ben_d;
        end
    end

endmodule

// File: tb/tb_reg_file_cc.sv
// Scoreboard bench for reg_file_cc: expected values are queued as stimulus is applied
// and popped against the DUT outputs at each sample point.
module tb_reg_file_cc;

    localparam int unsigned WIDTH = 16;

    localparam int SEL_SR1 = 0;
    localparam int SEL_SR2 = 1;
    localparam int SEL_NZP = 2;
    localparam int SEL_BEN = 3;

    typedef struct {
        string      tag;
        int         sel;
        logic [15:0] exp;
    } exp_t;

    logic clk;
    logic rst;

    reg_file_cc_if #(.WIDTH(WIDTH)) rf_if ();

    reg_file_cc #(
        .WIDTH (WIDTH),
        .NREG  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;

    logic [15:0] mregs [8];
    logic [2:0]  mnzp;
    logic        mben;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int sel, input logic [15:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_SR1: obs = rf_if.sr1_out;
                SEL_SR2: obs = rf_if.sr2_out;
                SEL_NZP: obs = {13'b0, rf_if.n, rf_if.z, rf_if.p};
                default: obs = {15'b0, rf_if.ben};
            endcase
            check_eq(e.tag, obs, e.exp);
        end
    endtask

    // Advance one clock, updating the reference model from the inputs seen at the edge.
    task automatic cycle();
        if (rst) begin
            for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
            mnzp = 3'b010;
            mben = 1'b0;
        end else begin
            if (rf_if.ld_ben) mben = |(rf_if.ir_cond & mnzp);
            if (rf_if.ld_cc) begin
                if (rf_if.bus[15])            mnzp = 3'b100;
                else if (rf_if.bus == 16'h0)  mnzp = 3'b010;
                else                          mnzp = 3'b001;
            end
            if (rf_if.ld_reg) mregs[rf_if.dr] = rf_if.bus;
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        rf_if.ld_reg  = 1'b0;
        rf_if.ld_cc   = 1'b0;
        rf_if.ld_ben  = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        rf_if.bus     = '0;
        rf_if.ld_reg  = 1'b0;
        rf_if.dr      = '0;
        rf_if.sr1     = '0;
        rf_if.sr2     = '0;
        rf_if.ld_cc   = 1'b0;
        rf_if.ld_ben  = 1'b0;
        rf_if.ir_cond = '0;
        for (int i = 0; i < 8; i++) mregs[i] = 16'hxxxx;
        mnzp = 3'bxxx;
        mben = 1'bx;

        @(negedge clk);
        rst = 1'b1;
        cycle();

        // Reset state
        for (int i = 0; i < 8; i++) begin
            rf_if.sr1 = 3'(i);
            rf_if.sr2 = 3'(7 - i);
            #1;
            push_exp("rst_sr1", SEL_SR1, 16'h0000);
            push_exp("rst_sr2", SEL_SR2, 16'h0000);
            drain();
        end
        push_exp("rst_nzp", SEL_NZP, 16'h0002);
        push_exp("rst_ben", SEL_BEN, 16'h0000);
        drain();

        // Write R3 with no bypass in the write cycle, then R7
        rf_if.dr = 3'd3; rf_if.bus = 16'h1234; rf_if.ld_reg = 1'b1; rf_if.sr1 = 3'd3;
        #1;
        push_exp("wr_no_bypass", SEL_SR1, 16'h0000);
        drain();
        cycle();
        push_exp("wr_r3_after", SEL_SR1, 16'h1234);
        drain();
        rf_if.dr = 3'd7; rf_if.bus = 16'hBEEF; rf_if.ld_reg = 1'b1;
        cycle();
        rf_if.sr1 = 3'd3; rf_if.sr2 = 3'd7;
        #1;
        push_exp("rd_r3", SEL_SR1, 16'h1234);
        push_exp("rd_r7", SEL_SR2, 16'hBEEF);
        drain();

        // Condition codes
        rf_if.bus = 16'h8000; rf_if.ld_cc = 1'b1; cycle();
        push_exp("cc_8000", SEL_NZP, 16'h0004); drain();
        rf_if.bus = 16'h0000; rf_if.ld_cc = 1'b1; cycle();
        push_exp("cc_0000", SEL_NZP, 16'h0002); drain();
        rf_if.bus = 16'h7FFF; rf_if.ld_cc = 1'b1; cycle();
        push_exp("cc_7fff", SEL_NZP, 16'h0001); drain();
        rf_if.bus = 16'hFFFF; cycle();
        push_exp("cc_hold", SEL_NZP, 16'h0001); drain();

        // BEN
        rf_if.ir_cond = 3'b001; rf_if.ld_ben = 1'b1; cycle();
        push_exp("ben_p", SEL_BEN, 16'h0001); drain();
        rf_if.ir_cond = 3'b110; rf_if.ld_ben = 1'b1; cycle();
        push_exp("ben_nz", SEL_BEN, 16'h0000); drain();
        rf_if.bus = 16'hFFFF; rf_if.ld_cc = 1'b1; rf_if.ir_cond = 3'b100; rf_if.ld_ben = 1'b1;
        cycle();
        push_exp("ben_old_nzp", SEL_BEN, 16'h0000);
        push_exp("ben_cc_par", SEL_NZP, 16'h0004);
        drain();
        rf_if.ir_cond = 3'b100; rf_if.ld_ben = 1'b1; cycle();
        push_exp("ben_new_n", SEL_BEN, 16'h0001); drain();
        rf_if.ir_cond = 3'b000; cycle();
        push_exp("ben_hold", SEL_BEN, 16'h0001); drain();

        // Reset mid-operation beats pending loads
        rf_if.dr = 3'd5; rf_if.bus = 16'hAAAA; rf_if.ld_reg = 1'b1; rf_if.ld_cc = 1'b1;
        cycle();
        rf_if.sr1 = 3'd5;
        #1;
        push_exp("r5_aaaa", SEL_SR1, 16'hAAAA);
        push_exp("nzp_aaaa", SEL_NZP, 16'h0004);
        drain();
        rst = 1'b1; rf_if.dr = 3'd5; rf_if.bus = 16'h5555;
        rf_if.ld_reg = 1'b1; rf_if.ld_cc = 1'b1; rf_if.ld_ben = 1'b1; rf_if.ir_cond = 3'b111;
        cycle();
        push_exp("rst_mid_r5", SEL_SR1, 16'h0000);
        push_exp("rst_mid_nzp", SEL_NZP, 16'h0002);
        push_exp("rst_mid_ben", SEL_BEN, 16'h0000);
        drain();

        // Same index on both read ports
        rf_if.dr = 3'd2; rf_if.bus = 16'h00FF; rf_if.ld_reg = 1'b1; cycle();
        rf_if.sr1 = 3'd2; rf_if.sr2 = 3'd2;
        #1;
        push_exp("dual_sr1", SEL_SR1, 16'h00FF);
        push_exp("dual_sr2", SEL_SR2, 16'h00FF);
        drain();

        // Random traffic against the reference model
        for (int k = 0; k < 80; k++) begin
            rf_if.ld_reg  = 1'($urandom_range(0, 1));
            rf_if.ld_cc   = 1'($urandom_range(0, 1));
            rf_if.ld_ben  = 1'($urandom_range(0, 1));
            rf_if.dr      = 3'($urandom_range(0, 7));
            rf_if.sr1     = 3'($urandom_range(0, 7));
            rf_if.sr2     = 3'($urandom_range(0, 7));
            rf_if.ir_cond = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       rf_if.bus = 16'h0000;
                1:       rf_if.bus = 16'h8000;
                2:       rf_if.bus = 16'h7FFF;
                default: rf_if.bus = 16'($urandom);
            endcase
            #1;
            push_exp("rnd_sr1", SEL_SR1, mregs[rf_if.sr1]);
            push_exp("rnd_sr2", SEL_SR2, mregs[rf_if.sr2]);
            drain();
            cycle();
            push_exp("rnd_nzp", SEL_NZP, {13'b0, mnzp});
            push_exp("rnd_ben", SEL_BEN, {15'b0, mben});
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
